// File: rtl/frame_timer_pkg.sv
// -----------------------------------------------------------------------------
// frame_timer_pkg
// Shared types and constants for the frame timer scheduler.
//   ch_state_t      : per-channel state (CH_IDLE / CH_RUN)
//   FRAME_DIV_60HZ  : clk cycles per 60 Hz frame at 50 MHz
//   FRAMES_125MS    : frame count for a ~125 ms delay
//   CH_*            : channel index assignment used by the game logic
//   div_width()     : prescaler counter width for a given divide ratio
// -----------------------------------------------------------------------------
package frame_timer_pkg;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_t;

  localparam int FRAME_DIV_60HZ = 833334;
  localparam int FRAMES_125MS   = 8;

  localparam int CH_SWING   = 0;
  localparam int CH_EXTEND  = 1;
  localparam int CH_GAMECLK = 2;
  localparam int CH_ANIM    = 3;

  // Counter must hold 0..div-1; never narrower than one bit.
  function automatic int div_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/frame_prescaler.sv
// -----------------------------------------------------------------------------
// frame_prescaler
// Shared frame timebase. Counts 0..FRAME_DIV-1 while any channel runs and
// emits a one-cycle tick on the last count. Parked at 0 whenever no channel
// is running, so a start from all-idle always sees a full first frame.
// Optional macro FRAME_TIMER_PAUSE_EN adds a pause input that freezes the
// count and suppresses the tick.
// Ports:
//   clk, resetn : clock, async active-low reset
//   run         : any channel busy
//   pause       : (FRAME_TIMER_PAUSE_EN only) freeze timebase
//   tick        : one-cycle frame tick, combinational from r_div_cnt/run
// -----------------------------------------------------------------------------
module frame_prescaler
  import frame_timer_pkg::*;
#(
  parameter int FRAME_DIV = FRAME_DIV_60HZ
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
`ifdef FRAME_TIMER_PAUSE_EN
  input  logic pause,
`endif
  output logic tick
);

  localparam int                DIV_W = div_width(FRAME_DIV);
  localparam logic [DIV_W-1:0]  LAST  = DIV_W'(FRAME_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic             w_hold;

`ifdef FRAME_TIMER_PAUSE_EN
  assign w_hold = pause;
`else
  assign w_hold = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_div_cnt <= '0;
    end else if (!run) begin
      // Idle timebase returns to phase 0 one cycle after the last channel stops.
      r_div_cnt <= '0;
    end else if (!w_hold) begin
      r_div_cnt <= (r_div_cnt == LAST) ? '0 : r_div_cnt + 1'b1;
    end
  end

  assign tick = run && !w_hold && (r_div_cnt == LAST);

endmodule

// File: rtl/frame_timer_scheduler.sv
// -----------------------------------------------------------------------------
// frame_timer_scheduler
// One shared frame prescaler plus NUM_CH frame-count timer channels. Each
// channel is loaded with a frame count on req[i] and pulses done[i] for one
// cycle when the count expires; periodic channels reload and keep running.
// Optional macro FRAME_TIMER_PAUSE_EN adds a pause input that freezes the
// timebase (and therefore all counts); req/cancel are still honoured.
// Ports:
//   clk, resetn : clock, async active-low reset
//   req[i]      : start/restart channel i (samples frames/periodic)
//   frames      : ch i count at [i*CNT_W +: CNT_W]; 0 = immediate done
//   periodic[i] : auto-reload after each expiry
//   cancel[i]   : stop channel i, no done; wins over req and tick
//   pause       : (FRAME_TIMER_PAUSE_EN only) freeze timebase
//   busy[i]     : channel i running
//   done[i]     : one-cycle expiry pulse
//   frame_tick  : shared one-cycle frame tick
// -----------------------------------------------------------------------------
module frame_timer_scheduler
  import frame_timer_pkg::*;
#(
  parameter int FRAME_DIV = FRAME_DIV_60HZ,
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_CH-1:0]       req,
  input  logic [NUM_CH*CNT_W-1:0] frames,
  input  logic [NUM_CH-1:0]       periodic,
  input  logic [NUM_CH-1:0]       cancel,
`ifdef FRAME_TIMER_PAUSE_EN
  input  logic                    pause,
`endif
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done,
  output logic                    frame_tick
);

  logic w_run;
  logic w_tick;

  assign w_run      = |busy;
  assign frame_tick = w_tick;

  frame_prescaler #(
    .FRAME_DIV (FRAME_DIV)
  ) u_prescaler (
    .clk    (clk),
    .resetn (resetn),
    .run    (w_run),
`ifdef FRAME_TIMER_PAUSE_EN
    .pause  (pause),
`endif
    .tick   (w_tick)
  );

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_t        r_state;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] r_reload;
    logic             r_per_q;
    logic             r_done;
    logic [CNT_W-1:0] w_frames;

    assign w_frames = frames[i*CNT_W +: CNT_W];

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_state     <= CH_IDLE;
        r_remaining <= '0;
        r_reload    <= '0;
        r_per_q     <= 1'b0;
        r_done      <= 1'b0;
      end else begin
        r_done <= 1'b0;
        if (cancel[i]) begin
          r_state     <= CH_IDLE;
          r_remaining <= '0;
        end else if (req[i]) begin
          // Restart ignores any tick in this cycle; the new count begins at
          // the next prescaler wrap, so a mid-run start gets a partial frame.
          r_reload    <= w_frames;
          r_remaining <= w_frames;
          r_per_q     <= periodic[i];
          if (w_frames == '0) begin
            r_state <= CH_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_state <= CH_RUN;
          end
        end else if (r_state == CH_RUN && w_tick) begin
          if (r_remaining == CNT_W'(1)) begin
            r_done <= 1'b1;
            if (r_per_q) begin
              r_remaining <= r_reload;
            end else begin
              r_remaining <= '0;
              r_state     <= CH_IDLE;
            end
          end else begin
            r_remaining <= r_remaining - 1'b1;
          end
        end
      end
    end

    assign busy[i] = (r_state == CH_RUN);
    assign done[i] = r_done;
  end

endmodule

// File: tb/tb_frame_timer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_frame_timer_scheduler
// Directed and randomized checks of frame_timer_scheduler (FRAME_DIV=4,
// NUM_CH=4, CNT_W=8). The reference model tracks an unbounded count of active
// timebase cycles and gives every running channel an absolute expiry deadline
// in that count; ticks fall on multiples of FRAME_DIV.
// -----------------------------------------------------------------------------
module tb_frame_timer_scheduler;

  localparam int FD  = 4;
  localparam int NCH = 4;
  localparam int CW  = 8;

  logic               clk      = 1'b0;
  logic               resetn   = 1'b0;
  logic [NCH-1:0]     req      = '0;
  logic [NCH-1:0]     periodic = '0;
  logic [NCH-1:0]     cancel   = '0;
  logic [NCH*CW-1:0]  frames   = '0;
  logic               pause    = 1'b0;
  logic [NCH-1:0]     busy;
  logic [NCH-1:0]     done;
  logic               frame_tick;

  always #5 clk = ~clk;

  frame_timer_scheduler #(
    .FRAME_DIV (FD),
    .NUM_CH    (NCH),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req        (req),
    .frames     (frames),
    .periodic   (periodic),
    .cancel     (cancel),
`ifdef FRAME_TIMER_PAUSE_EN
    .pause      (pause),
`endif
    .busy       (busy),
    .done       (done),
    .frame_tick (frame_tick)
  );

  // Reference model: A = active timebase cycles since the timebase started.
  int A;
  bit m_busy [NCH];
  bit m_done [NCH];
  bit m_per  [NCH];
  int m_D    [NCH];
  int m_rel  [NCH];

  int tests = 0;
  int fails = 0;
  int ecnt  = 0;
  int last_done [NCH];
  int done_cnt  [NCH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit any_busy();
    bit r = 1'b0;
    for (int c = 0; c < NCH; c++) r |= m_busy[c];
    return r;
  endfunction

  task automatic model_reset();
    A = 0;
    for (int c = 0; c < NCH; c++) begin
      m_busy[c] = 1'b0; m_done[c] = 1'b0; m_per[c] = 1'b0; m_D[c] = 0; m_rel[c] = 0;
    end
  endtask

  task automatic model_edge();
    bit act;
    int f;
    act = any_busy() && !pause;
    if (act) A++;
    for (int c = 0; c < NCH; c++) begin
      m_done[c] = 1'b0;
      f = int'(frames[c*CW +: CW]);
      if (cancel[c]) begin
        m_busy[c] = 1'b0;
      end else if (req[c]) begin
        if (f == 0) begin
          m_busy[c] = 1'b0;
          m_done[c] = 1'b1;
        end else begin
          m_busy[c] = 1'b1;
          m_rel[c]  = f;
          m_per[c]  = periodic[c];
          m_D[c]    = (A / FD + f) * FD;   // f-th frame boundary after now
        end
      end else if (m_busy[c] && act && A == m_D[c]) begin
        m_done[c] = 1'b1;
        if (m_per[c]) m_D[c] += m_rel[c] * FD;
        else          m_busy[c] = 1'b0;
      end
    end
    if (!any_busy()) A = 0;
  endtask

  // One clock: check the tick for the current cycle, advance, check state.
  task automatic cyc();
    bit exp_tick;
    exp_tick = any_busy() && !pause && ((A + 1) % FD == 0);
    chk("frame_tick", 32'(frame_tick), 32'(exp_tick));
    @(posedge clk);
    model_edge();
    ecnt++;
    #1;
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("busy%0d", c), 32'(busy[c]), 32'(m_busy[c]));
      chk($sformatf("done%0d", c), 32'(done[c]), 32'(m_done[c]));
      if (done[c]) begin
        last_done[c] = ecnt;
        done_cnt[c]++;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic start(input int ch, input int f, input bit p);
    req[ch] = 1'b1;
    frames[ch*CW +: CW] = CW'(f);
    periodic[ch] = p;
  endtask

  task automatic clr();
    req = '0;
    cancel = '0;
  endtask

  task automatic mark();
    for (int c = 0; c < NCH; c++) begin
      last_done[c] = -1;
      done_cnt[c]  = 0;
    end
  endtask

  initial begin
    int k, e, s;
    model_reset();
    mark();

    // Reset state
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tick", 32'(frame_tick), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;
    run(2);

    // One-shot, 3 frames from idle
    mark();
    start(0, 3, 1'b0); cyc(); k = ecnt; clr();
    run(14);
    chk("oneshot_edge", 32'(last_done[0]), 32'(k + 12));
    chk("oneshot_cnt", 32'(done_cnt[0]), 32'd1);
    chk("oneshot_busy", 32'(busy[0]), 32'd0);
    chk("oneshot_div0", 32'(dut.u_prescaler.r_div_cnt), 32'd0);

    // Periodic, 2 frames: pulse every 8 cycles, then cancel
    mark();
    start(1, 2, 1'b1); cyc(); k = ecnt; clr();
    run(40);
    chk("per_cnt", 32'(done_cnt[1]), 32'd5);
    chk("per_last", 32'(last_done[1]), 32'(k + 40));
    cancel[1] = 1'b1; cyc(); clr();
    chk("per_cancel_busy", 32'(busy[1]), 32'd0);
    mark();
    run(20);
    chk("per_cancel_nodone", 32'(done_cnt[1]), 32'd0);

    // Phase sharing: ch2 started two cycles before a wrap
    mark();
    start(0, 4, 1'b0); cyc(); k = ecnt; clr();
    cyc();
    start(2, 1, 1'b0); cyc(); e = ecnt; clr();
    run(16);
    chk("phase_ch2", 32'(last_done[2]), 32'(e + 2));
    chk("phase_ch0", 32'(last_done[0]), 32'(k + 16));
    chk("phase_cnt", 32'(done_cnt[0] + done_cnt[2]), 32'd2);

    // frames == 0: immediate single done, never busy
    mark();
    start(3, 0, 1'b1); cyc(); e = ecnt; clr();
    chk("zero_done", 32'(last_done[3]), 32'(e));
    chk("zero_busy", 32'(busy[3]), 32'd0);
    run(3);
    chk("zero_cnt", 32'(done_cnt[3]), 32'd1);

    // req + cancel in the same cycle
    mark();
    start(2, 3, 1'b0); cancel[2] = 1'b1; cyc(); clr();
    chk("reqcan_busy", 32'(busy[2]), 32'd0);
    run(16);
    chk("reqcan_nodone", 32'(done_cnt[2]), 32'd0);

    // Restart during RUN: old expiry suppressed, new count from next wrap
    mark();
    start(0, 2, 1'b0); cyc(); s = ecnt; clr();
    run(4);
    start(0, 5, 1'b0); cyc(); clr();
    run(22);
    chk("restart_edge", 32'(last_done[0]), 32'(s + 24));
    chk("restart_cnt", 32'(done_cnt[0]), 32'd1);

    // Simultaneous expiry
    mark();
    start(0, 2, 1'b0); start(1, 2, 1'b0); cyc(); k = ecnt; clr();
    run(10);
    chk("simul_ch0", 32'(last_done[0]), 32'(k + 8));
    chk("simul_ch1", 32'(last_done[1]), 32'(k + 8));

`ifdef FRAME_TIMER_PAUSE_EN
    // Pause 10 cycles mid-count shifts done by 10
    mark();
    start(0, 2, 1'b0); cyc(); k = ecnt; clr();
    run(3);
    pause = 1'b1; run(10); pause = 1'b0;
    run(12);
    chk("pause_edge", 32'(last_done[0]), 32'(k + 18));
`endif

    // Async reset while running: outputs clear at once, no later done
    start(0, 3, 1'b0); cyc(); clr();
    run(5);
    #3 resetn = 1'b0;
    #1;
    chk("amid_busy", 32'(busy), 32'd0);
    chk("amid_done", 32'(done), 32'd0);
    chk("amid_tick", 32'(frame_tick), 32'd0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;
    mark();
    run(20);
    chk("amid_nodone", 32'(done_cnt[0]), 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      for (int c = 0; c < NCH; c++) begin
        req[c]    = ($urandom_range(0, 9) == 0);
        cancel[c] = ($urandom_range(0, 24) == 0);
        frames[c*CW +: CW] = CW'($urandom_range(0, 3));
        periodic[c] = 1'($urandom_range(0, 1));
      end
`ifdef FRAME_TIMER_PAUSE_EN
      pause = ($urandom_range(0, 7) == 0);
`endif
      cyc();
    end
    clr();
    pause = 1'b0;
    run(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
